// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO, selectable parity and stop-bit count.
// Define UART_TX_LSB_FIRST_EN to send wr_data[0] first; by default the MSB goes first.
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 14,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk_3125,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              parity_en,
    input  logic              parity_type,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic              overflow,
    output logic              tx,
    output logic              tx_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W);

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
        return odd ? ~^d : ^d;
    endfunction

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_en_q, par_en_d, par_type_q, par_type_d;
    logic              tx_q, tx_d, tx_done_q, tx_done_d, busy_q, busy_d;
    logic              push_s, pop_s, bit_end_s;

    assign push_s    = wr_en & ~full_q;
    assign bit_end_s = (clk_cnt_q == CLK_LAST);

    // Frame sequencing: next state, pop request and word latch.
    always_comb begin
        state_d    = state_q;
        pop_s      = 1'b0;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q) begin
                    pop_s   = 1'b1;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_cnt_q == DATA_LAST)) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s && (bit_cnt_q == STOP_LAST)) begin
                    if (!empty_q) begin
                        pop_s   = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop_s) begin
            data_d     = mem_q[rd_ptr_q[AW-1:0]];
            par_en_d   = parity_en;
            par_type_d = parity_type;
        end else begin
            data_d = data_q;
        end
    end

    // Bit-period and bit-index counters; both restart on every state change.
    always_comb begin
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
        end else if (bit_end_s) begin
            clk_cnt_d = '0;
            bit_cnt_d = bit_cnt_q + BW'(1);
        end else begin
            clk_cnt_d = clk_cnt_q + CW'(1);
        end
    end

    // Outputs are computed from the next state so the flops line up with the state they describe.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
`ifdef UART_TX_LSB_FIRST_EN
            ST_DATA:   tx_d = data_d[bit_cnt_d];
`else
            ST_DATA:   tx_d = data_d[DATA_LAST - bit_cnt_d];
`endif
            ST_PARITY: tx_d = parity_bit(data_d, par_type_d);
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
        tx_done_d = (state_d == ST_STOP) && (bit_cnt_d == STOP_LAST) && (clk_cnt_d == CLK_LAST);
        busy_d    = (state_d != ST_IDLE);
    end

    // FIFO pointer arithmetic and registered status flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_s};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop_s};
        empty_d    = (wr_ptr_d == rd_ptr_d);
        full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        overflow_d = overflow_q | (wr_en & full_q);
    end

    // FIFO storage.
    always_ff @(posedge clk_3125) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_3125) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
            busy_q     <= busy_d;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign tx       = tx_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-level model checks the default instance every cycle,
// directed frames pin exact waveforms on three parameter sets.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       wr_en0 = 1'b0, pen0 = 1'b0, pt0 = 1'b0;
    logic [7:0] wr_data0 = 8'h00;
    logic       full0, empty0, busy0, ovf0, tx0, done0;
    logic       wr_en1 = 1'b0, pen1 = 1'b0, pt1 = 1'b0;
    logic [7:0] wr_data1 = 8'h00;
    logic       full1, empty1, busy1, ovf1, tx1, done1;
    logic       wr_en2 = 1'b0, pen2 = 1'b0, pt2 = 1'b0;
    logic [6:0] wr_data2 = 7'h00;
    logic       full2, empty2, busy2, ovf2, tx2, done2;

    uart_tx_fifo u0 (
        .clk_3125(clk), .reset(reset), .wr_en(wr_en0), .wr_data(wr_data0),
        .parity_en(pen0), .parity_type(pt0), .full(full0), .empty(empty0),
        .busy(busy0), .overflow(ovf0), .tx(tx0), .tx_done(done0));

    uart_tx_fifo #(.STOP_BITS(2)) u1 (
        .clk_3125(clk), .reset(reset), .wr_en(wr_en1), .wr_data(wr_data1),
        .parity_en(pen1), .parity_type(pt1), .full(full1), .empty(empty1),
        .busy(busy1), .overflow(ovf1), .tx(tx1), .tx_done(done1));

    uart_tx_fifo #(.DATA_W(7), .CLKS_PER_BIT(4)) u2 (
        .clk_3125(clk), .reset(reset), .wr_en(wr_en2), .wr_data(wr_data2),
        .parity_en(pen2), .parity_type(pt2), .full(full2), .empty(empty2),
        .busy(busy2), .overflow(ovf2), .tx(tx2), .tx_done(done2));

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // Frame-level model of u0 (DATA_W=8, 14 clocks/bit, depth 4, one stop bit).
    logic [7:0] m_q[$];
    logic       m_bits[0:15];
    int         m_len = 0;
    int         m_pos = -1;
    int         m_sz = 0;
    bit         m_fin = 1'b0;
    bit         m_ovf = 1'b0;
    bit         model_valid = 1'b0;

    function automatic void build(input logic [7:0] d, input logic pen, input logic pt);
        int n;
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
`ifdef UART_TX_LSB_FIRST_EN
            m_bits[1+i] = d[i];
`else
            m_bits[1+i] = d[7-i];
`endif
        end
        n = 9;
        if (pen) begin
            m_bits[n] = (($countones(d) % 2) == 1) ^ pt;
            n++;
        end
        m_bits[n] = 1'b1;
        n++;
        m_len = n * 14;
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_pos = -1;
            m_ovf = 1'b0;
            model_valid = 1'b1;
        end else begin
            m_sz  = m_q.size();
            m_fin = (m_pos >= 0) && (m_pos == m_len - 1);
            if ((m_pos < 0 || m_fin) && m_sz > 0) begin
                build(m_q.pop_front(), pen0, pt0);
                m_pos = 0;
            end else if (m_fin) begin
                m_pos = -1;
            end else if (m_pos >= 0) begin
                m_pos++;
            end
            if (wr_en0) begin
                if (m_sz == 4) m_ovf = 1'b1;
                else m_q.push_back(wr_data0);
            end
        end
    end

    logic e_tx;
    initial forever begin
        @(negedge clk);
        if (model_valid) begin
            e_tx = (m_pos < 0) ? 1'b1 : m_bits[m_pos / 14];
            chk("m_tx",    32'(tx0),    32'(e_tx));
            chk("m_busy",  32'(busy0),  32'(m_pos >= 0));
            chk("m_done",  32'(done0),  32'(m_pos >= 0 && m_pos == m_len - 1));
            chk("m_full",  32'(full0),  32'(m_q.size() == 4));
            chk("m_empty", 32'(empty0), 32'(m_q.size() == 0));
            chk("m_ovf",   32'(ovf0),   32'(m_ovf));
        end
    end

    function automatic logic get_tx(input int sel);
        case (sel)
            0: return tx0;
            1: return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    // exp_bits holds the frame with the first bit on the line at position nb-1.
    task automatic send_frame(input int sel, input logic [8:0] data, input logic pen, input logic pt,
                              input int cpb, input int nb, input logic [15:0] exp_bits,
                              input int exp_len, input string name);
        int done_at;
        int ndone;
        bit seen;
        @(negedge clk);
        case (sel)
            0: begin wr_en0 = 1'b1; wr_data0 = data[7:0]; pen0 = pen; pt0 = pt; end
            1: begin wr_en1 = 1'b1; wr_data1 = data[7:0]; pen1 = pen; pt1 = pt; end
            default: begin wr_en2 = 1'b1; wr_data2 = data[6:0]; pen2 = pen; pt2 = pt; end
        endcase
        @(negedge clk);
        wr_en0 = 1'b0; wr_en1 = 1'b0; wr_en2 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            if (get_tx(sel) == 1'b0) seen = 1'b1;
        end
        chk({name, "_start"}, 32'(seen), 32'd1);
        done_at = -1;
        ndone = 0;
        for (int c = 1; c <= exp_len + 4; c++) begin
            if (get_done(sel)) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (((c - 1) % cpb) == cpb / 2 && (c - 1) / cpb < nb)
                chk($sformatf("%s_bit%0d", name, (c - 1) / cpb), 32'(get_tx(sel)),
                    32'(exp_bits[nb - 1 - (c - 1) / cpb]));
            @(negedge clk);
        end
        chk({name, "_done_cycle"}, 32'(done_at), 32'(exp_len));
        chk({name, "_done_count"}, 32'(ndone), 32'd1);
    endtask

    int   ndone;
    int   nlow;
    logic [15:0] exp0f;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(tx0), 32'd1);
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_full", 32'(full0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        send_frame(0, 9'h0A5, 1'b1, 1'b0, 14, 11, 16'(11'b0_10100101_0_1), 154, "a5_even");
        send_frame(0, 9'h03C, 1'b1, 1'b1, 14, 11, 16'(11'b0_00111100_1_1), 154, "3c_odd");
        send_frame(1, 9'h0FF, 1'b0, 1'b0, 14, 11, 16'(11'b0_11111111_1_1), 154, "ff_2stop");
        send_frame(2, 9'h041, 1'b1, 1'b0, 4, 10, 16'(10'b0_1000001_0_1), 40, "w7_41");

        // Burst of five writes while a frame is already on the line.
        @(negedge clk);
        wr_en0 = 1'b1; wr_data0 = 8'h11; pen0 = 1'b1; pt0 = 1'b0;
        @(negedge clk);
        wr_en0 = 1'b0;
        @(negedge clk);
        chk("burst_busy", 32'(busy0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            wr_en0 = 1'b1;
            wr_data0 = 8'($urandom);
            @(negedge clk);
            if (i == 3) begin
                chk("burst_full4", 32'(full0), 32'd1);
                chk("burst_noovf4", 32'(ovf0), 32'd0);
            end
            if (i == 4) chk("burst_ovf5", 32'(ovf0), 32'd1);
        end
        wr_en0 = 1'b0;
        ndone = 0;
        for (int k = 0; k < 6 * 154 + 40; k++) begin
            if (done0) ndone++;
            if (!busy0) break;
            @(negedge clk);
        end
        chk("burst_frames", 32'(ndone), 32'd5);
        chk("burst_empty", 32'(empty0), 32'd1);
        chk("burst_idle", 32'(busy0), 32'd0);

        // Reset in the middle of the data bits of 0x55.
        @(negedge clk);
        wr_en0 = 1'b1; wr_data0 = 8'h55; pen0 = 1'b1; pt0 = 1'b0;
        @(negedge clk);
        wr_en0 = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_busy", 32'(busy0), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_tx", 32'(tx0), 32'd1);
        chk("mid_rst_busy", 32'(busy0), 32'd0);
        chk("mid_rst_empty", 32'(empty0), 32'd1);
        chk("mid_rst_full", 32'(full0), 32'd0);
        chk("mid_rst_ovf", 32'(ovf0), 32'd0);
        chk("mid_rst_done", 32'(done0), 32'd0);
        ndone = 0;
        nlow = 0;
        repeat (200) begin
            @(negedge clk);
            if (done0) ndone++;
            if (!tx0) nlow++;
        end
        chk("mid_no_done", 32'(ndone), 32'd0);
        chk("mid_tx_idle", 32'(nlow), 32'd0);
`ifdef UART_TX_LSB_FIRST_EN
        exp0f = 16'(11'b0_11110000_0_1);
`else
        exp0f = 16'(11'b0_00001111_0_1);
`endif
        send_frame(0, 9'h00F, 1'b1, 1'b0, 14, 11, exp0f, 154, "0f_after_rst");

        // Random traffic on u0, checked by the model every cycle.
        for (int k = 0; k < 8000; k++) begin
            @(negedge clk);
            wr_en0   = ($urandom_range(0, 99) < 2);
            wr_data0 = 8'($urandom);
            pen0     = 1'($urandom);
            pt0      = 1'($urandom);
            reset    = ($urandom_range(0, 2999) == 0);
        end
        @(negedge clk);
        wr_en0 = 1'b0;
        reset  = 1'b0;
        for (int k = 0; k < 6 * 154 + 20; k++) begin
            @(negedge clk);
            if (empty0 && !busy0) break;
        end
        chk("drain_empty", 32'(empty0), 32'd1);
        chk("drain_idle", 32'(busy0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
